// File: rtl/bpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bpu_pkg
//  Description : Types and constants shared by the branch resolution slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package bpu_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int c_bp_addr_w = 32;

    typedef struct packed {
        logic                   taken;
        logic                   backward;
        logic [c_bp_addr_w-1:0] pc;
        logic [c_bp_addr_w-1:0] target;
    } bp_entry_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } resolve_state_e;

endpackage
`default_nettype wire

// File: rtl/branch_resolve_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_ctrl_if
//  Description : Prediction/resolution inputs and redirect/training outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic                  pred_valid;
    logic                  pred_taken;
    logic [DATA_WIDTH-1:0] pred_pc;
    logic [DATA_WIDTH-1:0] pred_target;
    logic                  res_valid;
    logic                  res_taken;
    logic                  flush;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  upd_valid;
    logic                  upd_backward;
    logic                  upd_taken;
    logic                  full;
    logic [c_cnt_w-1:0]    count;
    logic                  err;

    modport master (
        output pred_valid, pred_taken, pred_pc, pred_target, res_valid, res_taken,
        input  flush, redirect_valid, redirect_pc, upd_valid, upd_backward,
               upd_taken, full, count, err
    );

    modport slave (
        input  pred_valid, pred_taken, pred_pc, pred_target, res_valid, res_taken,
        output flush, redirect_valid, redirect_pc, upd_valid, upd_backward,
               upd_taken, full, count, err
    );

endinterface
`default_nettype wire

// File: rtl/bp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bp_fifo
//  Description : Synchronous in-order FIFO of in-flight branch entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_fifo
    import bpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_push,
    input  wire logic                 i_pop,
    input  wire logic                 i_clear,
    input  wire bp_entry_t            i_wdata,
    output bp_entry_t                 o_rdata,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic                      o_full,
    output logic                      o_empty
);
    localparam int                 c_ptr_w    = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = 1;
    localparam logic [c_ptr_w:0]   c_cnt_one  = 1;
    localparam logic [c_ptr_w:0]   c_full_cnt = (c_ptr_w + 1)'(DEPTH);

    bp_entry_t          r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_ptr_w:0]   r_count;

    // Clear wins over push/pop: a squash discards the whole wrong path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + c_ptr_one;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = (r_count == c_full_cnt);
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_ctrl
//  Description : Tracks predicted branches, resolves them, redirects and trains.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_ctrl
    import bpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    branch_resolve_ctrl_if.slave  bus
);
    resolve_state_e        r_state;
    logic                  r_flush;
    logic                  r_redirect_valid;
    logic [DATA_WIDTH-1:0] r_redirect_pc;
    logic                  r_upd_valid;
    logic                  r_upd_backward;
    logic                  r_upd_taken;
    logic                  r_err;

    bp_entry_t             w_push_entry;
    bp_entry_t             w_head;
    logic [$clog2(DEPTH):0] w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_run;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_mispredict;
    logic                  w_err_evt;
    logic [DATA_WIDTH-1:0] w_head_pc;
    logic [DATA_WIDTH-1:0] w_head_target;
    logic [DATA_WIDTH-1:0] w_redirect_pc;

    always_comb begin
        w_push_entry          = '0;
        w_push_entry.taken    = bus.pred_taken;
        w_push_entry.backward = (bus.pred_target < bus.pred_pc);
        w_push_entry.pc       = c_bp_addr_w'(bus.pred_pc);
        w_push_entry.target   = c_bp_addr_w'(bus.pred_target);
    end

    assign w_run        = (r_state == RUN);
    assign w_pop        = w_run && bus.res_valid && !w_empty;
    assign w_mispredict = w_pop && (w_head.taken != bus.res_taken);
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_push       = w_run && bus.pred_valid && (!w_full || w_pop) && !w_mispredict;
    assign w_err_evt    = w_run && ((bus.res_valid && w_empty) ||
                                    (bus.pred_valid && w_full && !w_pop));

    assign w_head_pc     = DATA_WIDTH'(w_head.pc);
    assign w_head_target = DATA_WIDTH'(w_head.target);
    assign w_redirect_pc = bus.res_taken ? w_head_target
                                         : w_head_pc + DATA_WIDTH'(INSTR_BYTES);

    bp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_mispredict),
        .i_wdata (w_push_entry),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= RUN;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_upd_valid      <= 1'b0;
            r_upd_backward   <= 1'b0;
            r_upd_taken      <= 1'b0;
            r_err            <= 1'b0;
        end else begin
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_upd_valid      <= 1'b0;
            r_upd_backward   <= 1'b0;
            r_upd_taken      <= 1'b0;
            if (w_err_evt) begin
                r_err <= 1'b1;
            end
            case (r_state)
                RUN: begin
                    if (w_pop) begin
                        r_upd_valid    <= 1'b1;
                        r_upd_backward <= w_head.backward;
                        r_upd_taken    <= bus.res_taken;
                    end
                    if (w_mispredict) begin
                        r_state          <= REDIRECT;
                        r_flush          <= 1'b1;
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= w_redirect_pc;
                    end
                end
                REDIRECT: r_state <= DRAIN;
                DRAIN:    r_state <= RUN;
                default:  r_state <= RUN;
            endcase
        end
    end

    assign bus.flush          = r_flush;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.upd_valid      = r_upd_valid;
    assign bus.upd_backward   = r_upd_backward;
    assign bus.upd_taken      = r_upd_taken;
    assign bus.full           = w_full;
    assign bus.count          = w_count;
    assign bus.err            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve_ctrl
//  Description : Scoreboard bench for branch_resolve_ctrl against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef struct {
        bit          taken;
        bit          backward;
        logic [31:0] pc;
        logic [31:0] target;
    } mdl_entry_t;

    typedef struct {
        bit          backward;
        bit          taken;
        bit          flush;
        logic [31:0] rpc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    branch_resolve_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    branch_resolve_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    mdl_entry_t q[$];
    exp_t       exp_q[$];
    bit         m_err    = 1'b0;
    int         blk      = 0;
    bit         chk_rst  = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock of stimulus: check the state left by the previous edge, then drive.
    task automatic step(input bit r, input bit pv, input bit pt,
                        input logic [31:0] ppc, input logic [31:0] ptgt,
                        input bit rv, input bit rt);
        mdl_entry_t h;
        mdl_entry_t n;
        exp_t       e;
        @(negedge clk);
        chk("count", bus.count, q.size());
        chk("full", bus.full, (q.size() == DEPTH));
        chk("err", bus.err, m_err);
        if (chk_rst) begin
            chk("rst_flush", bus.flush, 0);
            chk("rst_redirect_valid", bus.redirect_valid, 0);
            chk("rst_redirect_pc", bus.redirect_pc, 0);
            chk("rst_upd_valid", bus.upd_valid, 0);
            chk("rst_upd_backward", bus.upd_backward, 0);
            chk("rst_upd_taken", bus.upd_taken, 0);
        end
        rst             = r;
        bus.pred_valid  = pv;
        bus.pred_taken  = pt;
        bus.pred_pc     = ppc;
        bus.pred_target = ptgt;
        bus.res_valid   = rv;
        bus.res_taken   = rt;
        chk_rst         = r;
        if (r) begin
            q.delete();
            blk   = 0;
            m_err = 1'b0;
        end else if (blk > 0) begin
            blk--;
        end else begin
            if (rv) begin
                if (q.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    h          = q.pop_front();
                    e.backward = h.backward;
                    e.taken    = rt;
                    e.flush    = (h.taken != rt);
                    e.rpc      = e.flush ? (rt ? h.target : h.pc + 32'd4) : 32'd0;
                    exp_q.push_back(e);
                    if (e.flush) begin
                        q.delete();
                        blk = 2;
                    end
                end
            end
            if (pv && blk == 0) begin
                if (q.size() < DEPTH) begin
                    n.taken    = pt;
                    n.backward = (ptgt < ppc);
                    n.pc       = ppc;
                    n.target   = ptgt;
                    q.push_back(n);
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic push(input bit pt, input logic [31:0] pc, input logic [31:0] tgt);
        step(1'b0, 1'b1, pt, pc, tgt, 1'b0, 1'b0);
    endtask

    task automatic resolve(input bit rt);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, rt);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // Monitor: outputs produced by each edge are compared against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.upd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_update: upd_valid=1 required 0 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("upd_backward", bus.upd_backward, e.backward);
                    chk("upd_taken", bus.upd_taken, e.taken);
                    chk("flush", bus.flush, e.flush);
                    chk("redirect_valid", bus.redirect_valid, e.flush);
                    chk("redirect_pc", bus.redirect_pc, e.rpc);
                end
            end else begin
                chk("idle_flush", bus.flush, 0);
                chk("idle_redirect_valid", bus.redirect_valid, 0);
            end
        end
    end

    initial begin
        bus.pred_valid  = 1'b0;
        bus.pred_taken  = 1'b0;
        bus.pred_pc     = '0;
        bus.pred_target = '0;
        bus.res_valid   = 1'b0;
        bus.res_taken   = 1'b0;

        do_reset();
        // Correct forward taken prediction
        push(1'b1, 32'h100, 32'h120);
        resolve(1'b1);
        idle();
        // Not-taken backward branch actually taken; pushes ignored for two cycles
        push(1'b0, 32'h200, 32'h1F0);
        resolve(1'b1);
        push(1'b1, 32'h210, 32'h220);
        push(1'b1, 32'h214, 32'h224);
        idle();
        // Taken prediction actually not taken: fall-through redirect
        push(1'b1, 32'h300, 32'h340);
        resolve(1'b0);
        idle();
        idle();
        idle();
        // Fill, overflow, then push+pop while full
        for (int i = 0; i < DEPTH; i++) push(1'b1, 32'h400 + 32'(16 * i), 32'h408 + 32'(16 * i));
        push(1'b1, 32'h480, 32'h490);
        step(1'b0, 1'b1, 1'b1, 32'h4A0, 32'h4B0, 1'b1, 1'b1);
        for (int i = 0; i < DEPTH; i++) resolve(1'b1);
        idle();
        // Mispredict with three queued and a same-cycle push
        do_reset();
        for (int i = 0; i < 3; i++) push(1'b1, 32'h800 + 32'(8 * i), 32'h900);
        step(1'b0, 1'b1, 1'b1, 32'h880, 32'h890, 1'b1, 1'b0);
        idle();
        idle();
        idle();
        // Resolve on empty queue, then reset in the middle of a redirect
        do_reset();
        resolve(1'b1);
        push(1'b0, 32'hA00, 32'hA40);
        resolve(1'b1);
        do_reset();
        push(1'b1, 32'hB00, 32'hAF0);
        resolve(1'b1);
        idle();

        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle();
        idle();
        idle();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Sequences branch resolution for the pipelined core's branch predictor.
- Holds every predicted branch in flight between Fetch and Execute in an ordered queue.
- Compares each prediction with the actual Execute outcome, then issues flush/redirect on a mispredict and a training strobe to the predictor's saturating counters.
- Sits between the predictor (prediction source/counter owner), the PC mux and the hazard unit.

Parameters:
DATA_WIDTH, 32, PC/address width
DEPTH, 4, in-flight branch queue entries (power of two, >=2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
pred_valid  in  1  predictor has issued a prediction for a branch in Fetch this cycle
pred_taken  in  1  predicted direction
pred_pc  in  DATA_WIDTH  PC of the predicted branch
pred_target  in  DATA_WIDTH  computed branch target
res_valid  in  1  oldest in-flight branch resolves in Execute this cycle
res_taken  in  1  actual direction (condition true)
flush  out  1  flush Fetch/Decode pipeline registers
redirect_valid  out  1  PC mux must select redirect_pc
redirect_pc  out  DATA_WIDTH  corrected fetch PC
upd_valid  out  1  train predictor counter this cycle
upd_backward  out  1  trained branch was backward (target < pc, unsigned)
upd_taken  out  1  actual direction for training
full  out  1  queue full; Fetch must stall
count  out  $clog2(DEPTH)+1  current queue occupancy
err  out  1  sticky protocol error

Behaviour:
- Queue entry: {taken, backward, pc, target}. backward = (pred_target < pred_pc), computed at push.
- Push: pred_valid && !full && state==RUN. Pop: res_valid && count!=0.
- Push and pop in the same cycle: both occur; count unchanged. Valid also when full (pop frees the slot the push uses).
- Pop compare, head.taken vs res_taken:
  - Match: no flush.
  - Mismatch: next state REDIRECT; entire queue cleared at the same edge (all younger entries are wrong-path); a same-cycle push is discarded.
- Outputs are registered; latency is res_valid at edge N -> outputs valid during cycle N+1 for one cycle:
  - upd_valid=1, upd_backward=head.backward, upd_taken=res_taken, on every pop.
  - flush=1, redirect_valid=1 only on mismatch.
  - redirect_pc = res_taken ? head.target : head.pc+4 (modulo 2^DATA_WIDTH).
- FSM:
  - RUN: normal operation.
  - REDIRECT: one cycle, outputs asserted; pushes ignored; -> DRAIN.
  - DRAIN: one cycle; pushes ignored (wrong-path Fetch still in flight); -> RUN.
- res_valid during REDIRECT/DRAIN: ignored; queue already empty.
- Errors (err is sticky; the violating push/pop has no effect):
  - res_valid in RUN with count==0: err=1.
  - pred_valid with full (no simultaneous pop) in RUN: err=1.
- Pointer wrap: read/write pointers are $clog2(DEPTH) bits, wrap modulo DEPTH. full = (count==DEPTH).
- Reset (any cycle, including mid-REDIRECT): state=RUN, pointers=0, count=0.
- Output reset values: flush=0, redirect_valid=0, redirect_pc=0, upd_valid=0, upd_backward=0, upd_taken=0, err=0, full=0.

Decomposition:
- Shared package bpu_pkg holds:
  - typedef bp_entry_t (packed struct taken/backward/pc/target).
  - enum resolve_state_e {RUN, REDIRECT, DRAIN}.
  - localparam INSTR_BYTES=4.
- One sub-module: bp_fifo (parameterised synchronous FIFO of bp_entry_t with push/pop/clear/count/full/empty).
- Controller FSM and compare/redirect logic stay in branch_resolve_ctrl.

Test Plan:
- Reset, then push taken fwd branch pc=0x100 target=0x120, resolve res_taken=1 -> cycle+1: upd_valid=1, upd_backward=0, upd_taken=1, flush=0, count=0.
- Push not-taken pc=0x200 target=0x1F0, resolve res_taken=1 -> cycle+1: flush=1, redirect_valid=1, redirect_pc=0x1F0, upd_backward=1; next two cycles pred_valid ignored, count stays 0.
- Push taken pc=0x300 target=0x340, resolve res_taken=0 -> redirect_pc=0x304, flush=1 for exactly one cycle.
- Push 4 entries (DEPTH=4) -> full=1, count=4; 5th push without pop -> err=1, count=4; simultaneous push+pop when full -> count stays 4, err unchanged.
- 3 entries queued, head mispredicts while pred_valid=1 -> count=0 after edge, pushed entry discarded.
- res_valid with empty queue -> err=1, no upd_valid; assert rst during REDIRECT -> next cycle all outputs 0, state RUN.
